// File: rtl/rd_ctrl_pkg.sv
// Shared helpers for the FIFO read controller: Gray/binary conversion and
// elaboration-time legality checks for the controller parameters.
package rd_ctrl_pkg;

  localparam int unsigned MaxWidth = 32;

  // Upper bits of narrower operands are zero-extended, so the loop is width-agnostic.
  function automatic logic [MaxWidth-1:0] bin2gray(input logic [MaxWidth-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  function automatic logic [MaxWidth-1:0] gray2bin(input logic [MaxWidth-1:0] gray);
    logic [MaxWidth-1:0] bin;
    bin = gray;
    for (int i = MaxWidth - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

  // A single flop gives no metastability protection; 0 means already synchronous.
  function automatic bit sync_stages_legal(input int unsigned stages);
    return stages != 1;
  endfunction

  function automatic bit aempty_thr_legal(input int unsigned thr, input int unsigned awidth);
    return thr <= (32'd1 << awidth);
  endfunction

endpackage

// File: rtl/rd_ctrl_sync_sync_chain.sv
// Multi-flop synchroniser with asynchronous active-low clear; pure wire when STAGES is 0.
module sync_chain #(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk_i,
  input  logic             aclr_n_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  if (STAGES == 0) begin : g_bypass
    logic unused_clk_rst;
    assign unused_clk_rst = clk_i ^ aclr_n_i;
    assign q_o = d_i;
  end else begin : g_flops
    logic [WIDTH-1:0] stage_q [STAGES];

    always_ff @(posedge clk_i or negedge aclr_n_i) begin
      if (!aclr_n_i) begin
        for (int i = 0; i < int'(STAGES); i++) stage_q[i] <= '0;
      end else begin
        stage_q[0] <= d_i;
        for (int i = 1; i < int'(STAGES); i++) stage_q[i] <= stage_q[i-1];
      end
    end

    assign q_o = stage_q[STAGES-1];
  end

endmodule

// File: rtl/rd_ctrl_sync.sv
// Read-domain controller of a dual-clock FIFO: read pointer, write-pointer
// synchroniser, registered empty/almost-empty/count/underflow flags.
module rd_ctrl_sync
  import rd_ctrl_pkg::*;
#(
  parameter int unsigned AWIDTH      = 3,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned AEMPTY_THR  = 1
) (
  input  logic              rd_clk_i,
  input  logic              aclr_n_i,
  input  logic              rd_req_i,
  input  logic [AWIDTH:0]   wr_pntr_gray_i,
  output logic [AWIDTH-1:0] rd_addr_o,
  output logic              rd_ram_en_o,
  output logic [AWIDTH:0]   rd_pntr_gray_o,
  output logic              rd_empty_o,
  output logic              rd_almost_empty_o,
  output logic [AWIDTH:0]   rd_usedw_o,
  output logic              rd_underflow_o
);

  localparam int unsigned PW = AWIDTH + 1;
  localparam logic [PW-1:0] AemptyThr = PW'(AEMPTY_THR);

  if (!sync_stages_legal(SYNC_STAGES)) begin : g_bad_sync_stages
    $error("rd_ctrl_sync: SYNC_STAGES must be 0 or >= 2");
  end
  if (!aempty_thr_legal(AEMPTY_THR, AWIDTH)) begin : g_bad_aempty_thr
    $error("rd_ctrl_sync: AEMPTY_THR must not exceed 2**AWIDTH");
  end

  logic [PW-1:0] wr_gray_s, wr_bin_s;
  logic [PW-1:0] rd_bin_q, rd_bin_d;
  logic [PW-1:0] rd_gray_q, rd_gray_d;
  logic [PW-1:0] usedw_q, usedw_d;
  logic          empty_q, empty_d;
  logic          aempty_q, aempty_d;
  logic          uflow_q, uflow_d;
  logic          rd_ack;

  sync_chain #(
    .WIDTH  (PW),
    .STAGES (SYNC_STAGES)
  ) u_wr_sync (
    .clk_i    (rd_clk_i),
    .aclr_n_i (aclr_n_i),
    .d_i      (wr_pntr_gray_i),
    .q_o      (wr_gray_s)
  );

  always_comb begin
    wr_bin_s  = PW'(gray2bin(MaxWidth'(wr_gray_s)));
    rd_ack    = rd_req_i & ~empty_q;
    rd_bin_d  = rd_bin_q + {{AWIDTH{1'b0}}, rd_ack};
    rd_gray_d = PW'(bin2gray(MaxWidth'(rd_bin_d)));
    empty_d   = (rd_gray_d == wr_gray_s);
    // PW-bit difference keeps a completely full FIFO (2**AWIDTH) distinct from empty.
    usedw_d   = wr_bin_s - rd_bin_d;
    aempty_d  = (usedw_d <= AemptyThr);
    uflow_d   = rd_req_i & empty_q;
  end

  always_ff @(posedge rd_clk_i or negedge aclr_n_i) begin
    if (!aclr_n_i) begin
      rd_bin_q  <= '0;
      rd_gray_q <= '0;
      usedw_q   <= '0;
      empty_q   <= 1'b1;
      aempty_q  <= 1'b1;
      uflow_q   <= 1'b0;
    end else begin
      rd_bin_q  <= rd_bin_d;
      rd_gray_q <= rd_gray_d;
      usedw_q   <= usedw_d;
      empty_q   <= empty_d;
      aempty_q  <= aempty_d;
      uflow_q   <= uflow_d;
    end
  end

  assign rd_addr_o         = rd_bin_q[AWIDTH-1:0];
  assign rd_ram_en_o       = rd_ack;
  assign rd_pntr_gray_o    = rd_gray_q;
  assign rd_empty_o        = empty_q;
  assign rd_almost_empty_o = aempty_q;
  assign rd_usedw_o        = usedw_q;
  assign rd_underflow_o    = uflow_q;

endmodule

// File: tb/tb_rd_ctrl_sync.sv
// Directed, table-driven bench for rd_ctrl_sync (AWIDTH=3, SYNC_STAGES=2, AEMPTY_THR=2).
module tb_rd_ctrl_sync;

  logic       clk = 1'b0;
  logic       aclr_n;
  logic       req;
  logic [3:0] wr_gray;
  logic [2:0] addr;
  logic       ram_en;
  logic [3:0] rd_gray;
  logic       empty;
  logic       aempty;
  logic [3:0] usedw;
  logic       uflow;

  int checks = 0;
  int failures = 0;

  rd_ctrl_sync #(
    .AWIDTH      (3),
    .SYNC_STAGES (2),
    .AEMPTY_THR  (2)
  ) dut (
    .rd_clk_i          (clk),
    .aclr_n_i          (aclr_n),
    .rd_req_i          (req),
    .wr_pntr_gray_i    (wr_gray),
    .rd_addr_o         (addr),
    .rd_ram_en_o       (ram_en),
    .rd_pntr_gray_o    (rd_gray),
    .rd_empty_o        (empty),
    .rd_almost_empty_o (aempty),
    .rd_usedw_o        (usedw),
    .rd_underflow_o    (uflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       req;
    logic [3:0] wr_gray;
    logic [2:0] addr;
    logic       en;
    logic       empty;
    logic       aempty;
    logic [3:0] usedw;
    logic       uflow;
    logic [3:0] gray;
  } vec_t;

  vec_t vecs [21];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".empty"}, 32'(empty), 32'd1);
    chk({tag, ".aempty"}, 32'(aempty), 32'd1);
    chk({tag, ".usedw"}, 32'(usedw), 32'd0);
    chk({tag, ".addr"}, 32'(addr), 32'd0);
    chk({tag, ".gray"}, 32'(rd_gray), 32'd0);
    chk({tag, ".uflow"}, 32'(uflow), 32'd0);
    chk({tag, ".ram_en"}, 32'(ram_en), 32'd0);
  endtask

  initial begin
    //        req wr       addr en empty aemp usedw uf gray
    // fill: write pointer to bin 4, visible 3 edges later
    vecs[0]  = '{1'b0, 4'b0110, 3'd0, 1'b0, 1'b1, 1'b1, 4'd0, 1'b0, 4'b0000};
    vecs[1]  = '{1'b0, 4'b0110, 3'd0, 1'b0, 1'b1, 1'b1, 4'd0, 1'b0, 4'b0000};
    vecs[2]  = '{1'b0, 4'b0110, 3'd0, 1'b0, 1'b0, 1'b0, 4'd4, 1'b0, 4'b0000};
    // drain 4 back-to-back
    vecs[3]  = '{1'b1, 4'b0110, 3'd0, 1'b1, 1'b0, 1'b0, 4'd3, 1'b0, 4'b0001};
    vecs[4]  = '{1'b1, 4'b0110, 3'd1, 1'b1, 1'b0, 1'b1, 4'd2, 1'b0, 4'b0011};
    vecs[5]  = '{1'b1, 4'b0110, 3'd2, 1'b1, 1'b0, 1'b1, 4'd1, 1'b0, 4'b0010};
    vecs[6]  = '{1'b1, 4'b0110, 3'd3, 1'b1, 1'b1, 1'b1, 4'd0, 1'b0, 4'b0110};
    // underflow while empty
    vecs[7]  = '{1'b1, 4'b0110, 3'd4, 1'b0, 1'b1, 1'b1, 4'd0, 1'b1, 4'b0110};
    vecs[8]  = '{1'b1, 4'b0110, 3'd4, 1'b0, 1'b1, 1'b1, 4'd0, 1'b1, 4'b0110};
    vecs[9]  = '{1'b0, 4'b0110, 3'd4, 1'b0, 1'b1, 1'b1, 4'd0, 1'b0, 4'b0110};
    // write pointer to bin 12: full, count 8
    vecs[10] = '{1'b0, 4'b1010, 3'd4, 1'b0, 1'b1, 1'b1, 4'd0, 1'b0, 4'b0110};
    vecs[11] = '{1'b0, 4'b1010, 3'd4, 1'b0, 1'b1, 1'b1, 4'd0, 1'b0, 4'b0110};
    vecs[12] = '{1'b0, 4'b1010, 3'd4, 1'b0, 1'b0, 1'b0, 4'd8, 1'b0, 4'b0110};
    // read 8 across the wrap
    vecs[13] = '{1'b1, 4'b1010, 3'd4, 1'b1, 1'b0, 1'b0, 4'd7, 1'b0, 4'b0111};
    vecs[14] = '{1'b1, 4'b1010, 3'd5, 1'b1, 1'b0, 1'b0, 4'd6, 1'b0, 4'b0101};
    vecs[15] = '{1'b1, 4'b1010, 3'd6, 1'b1, 1'b0, 1'b0, 4'd5, 1'b0, 4'b0100};
    vecs[16] = '{1'b1, 4'b1010, 3'd7, 1'b1, 1'b0, 1'b0, 4'd4, 1'b0, 4'b1100};
    vecs[17] = '{1'b1, 4'b1010, 3'd0, 1'b1, 1'b0, 1'b0, 4'd3, 1'b0, 4'b1101};
    vecs[18] = '{1'b1, 4'b1010, 3'd1, 1'b1, 1'b0, 1'b1, 4'd2, 1'b0, 4'b1111};
    vecs[19] = '{1'b1, 4'b1010, 3'd2, 1'b1, 1'b0, 1'b1, 4'd1, 1'b0, 4'b1110};
    vecs[20] = '{1'b1, 4'b1010, 3'd3, 1'b1, 1'b1, 1'b1, 4'd0, 1'b0, 4'b1010};

    // reset held 3 cycles with a pending request
    aclr_n  = 1'b0;
    req     = 1'b1;
    wr_gray = 4'b0000;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals("reset");
    req    = 1'b0;
    aclr_n = 1'b1;

    for (int i = 0; i < 21; i++) begin
      req     = vecs[i].req;
      wr_gray = vecs[i].wr_gray;
      #1;
      chk($sformatf("v%0d.addr", i), 32'(addr), 32'(vecs[i].addr));
      chk($sformatf("v%0d.ram_en", i), 32'(ram_en), 32'(vecs[i].en));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d.empty", i), 32'(empty), 32'(vecs[i].empty));
      chk($sformatf("v%0d.aempty", i), 32'(aempty), 32'(vecs[i].aempty));
      chk($sformatf("v%0d.usedw", i), 32'(usedw), 32'(vecs[i].usedw));
      chk($sformatf("v%0d.uflow", i), 32'(uflow), 32'(vecs[i].uflow));
      chk($sformatf("v%0d.gray", i), 32'(rd_gray), 32'(vecs[i].gray));
      chk($sformatf("v%0d.inv", i), 32'(empty), 32'(usedw == 4'd0));
    end

    // mid-burst reset: write pointer to bin 1 (wrapped) -> count 5 from read pointer 12
    req     = 1'b0;
    wr_gray = 4'b0001;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    chk("mid.usedw5", 32'(usedw), 32'd5);
    req = 1'b1;
    #1;
    chk("mid.ram_en", 32'(ram_en), 32'd1);
    chk("mid.addr", 32'(addr), 32'd4);
    @(posedge clk);
    #1;
    chk("mid.usedw4", 32'(usedw), 32'd4);
    chk("mid.addr5", 32'(addr), 32'd5);
    #2;
    aclr_n = 1'b0;
    #1;
    chk_reset_vals("async_rst");
    wr_gray = 4'b0000;
    req     = 1'b0;
    @(posedge clk);
    #1;
    aclr_n = 1'b1;
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    chk("post_rst.empty", 32'(empty), 32'd1);
    chk("post_rst.usedw", 32'(usedw), 32'd0);
    chk("post_rst.gray", 32'(rd_gray), 32'd0);
    req = 1'b1;
    #1;
    chk("post_rst.ram_en", 32'(ram_en), 32'd0);
    @(posedge clk);
    #1;
    chk("post_rst.uflow", 32'(uflow), 32'd1);
    chk("post_rst.addr", 32'(addr), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
